pulse_train_generator: RTL and testbench

- Stimulus source at the far end of the pulse-measurement path: drives pulse_out into the pulse-width measurement input.
- Started and stopped by the PC start/stop commands after they are synchronized into the fast clock domain.
- Emits high pulses of pseudo-random, bounded width separated by a fixed low gap.
- Reports pulse count and last width so emitted widths can be reconciled against histogram bins.

---
 rtl/pulse_train_generator_pkg.sv | 13 +
 rtl/pulse_width_source.sv | 46 ++++
 rtl/pulse_train_generator.sv | 111 +++++++++++
 tb/tb_pulse_train_generator.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_train_generator_pkg.sv
// Shared types and constants for the pulse train generator and its width source.
package pulse_train_generator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_e;

  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam int          COUNT_BITS = 16;

endpackage

// File: rtl/pulse_width_source.sv
// Supplies the width of the next pulse; PULSE_GEN_SWEEP_EN swaps the LFSR for a
// linear sweep counter so every histogram bin gets exactly one hit per sweep.
module pulse_width_source
  import pulse_train_generator_pkg::*;
#(
  parameter int          WIDTH_BITS = 9,
  parameter int          MIN_WIDTH  = 4,
  parameter int          RANGE_BITS = 8,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  areset_n,
  input  logic                  advance_i,
  output logic [WIDTH_BITS-1:0] width_o
);

`ifdef PULSE_GEN_SWEEP_EN
  logic [RANGE_BITS-1:0] sweep_q;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      sweep_q <= '0;
    end else if (advance_i) begin
      sweep_q <= sweep_q + RANGE_BITS'(1);
    end
  end

  assign width_o = WIDTH_BITS'(MIN_WIDTH) + WIDTH_BITS'(sweep_q);
`else
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // The width is taken from the value the LFSR is about to step to.
  assign lfsr_d  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  assign width_o = WIDTH_BITS'(MIN_WIDTH) + WIDTH_BITS'(lfsr_d[RANGE_BITS-1:0]);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      lfsr_q <= SEED;
    end else if (advance_i) begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

endmodule

// File: rtl/pulse_train_generator.sv
// Emits bounded-width high pulses separated by a fixed gap between start/stop events.
// Build option PULSE_GEN_SWEEP_EN selects sweep widths instead of pseudo-random ones.
module pulse_train_generator
  import pulse_train_generator_pkg::*;
#(
  parameter int          WIDTH_BITS = 9,
  parameter int          MIN_WIDTH  = 4,
  parameter int          RANGE_BITS = 8,
  parameter int          GAP_CYCLES = 8,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  areset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  bram_reset_done,
  output logic                  pulse_out,
  output logic                  busy,
  output logic [15:0]           pulse_count,
  output logic [WIDTH_BITS-1:0] last_width
);

  localparam logic [WIDTH_BITS-1:0] W_ONE    = WIDTH_BITS'(1);
  localparam logic [WIDTH_BITS-1:0] GAP_LOAD = WIDTH_BITS'(GAP_CYCLES - 1);

  state_e                  state_q;
  logic                    start_q, stop_q, stop_pending_q, pulse_q;
  logic [WIDTH_BITS-1:0]   cnt_q, last_width_q, next_width;
  logic [COUNT_BITS-1:0]   count_q;
  logic                    start_rise, stop_rise, start_accept, gap_done, reload, advance;

  assign start_rise   = start & ~start_q;
  assign stop_rise    = stop & ~stop_q;
  assign start_accept = (state_q == IDLE) & start_rise & bram_reset_done & ~stop_rise;
  assign gap_done     = (state_q == LOW) & (cnt_q == '0);
  assign reload       = gap_done & ~(stop_pending_q | stop_rise);
  assign advance      = start_accept | reload;

  pulse_width_source #(
    .WIDTH_BITS(WIDTH_BITS),
    .MIN_WIDTH (MIN_WIDTH),
    .RANGE_BITS(RANGE_BITS),
    .SEED      (SEED)
  ) u_width (
    .clk      (clk),
    .areset_n (areset_n),
    .advance_i(advance),
    .width_o  (next_width)
  );

  // cnt_q holds the cycles remaining in the current high or low phase, minus one.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q        <= IDLE;
      start_q        <= 1'b0;
      stop_q         <= 1'b0;
      stop_pending_q <= 1'b0;
      pulse_q        <= 1'b0;
      cnt_q          <= '0;
      last_width_q   <= '0;
      count_q        <= '0;
    end else begin
      start_q <= start;
      stop_q  <= stop;
      case (state_q)
        IDLE: begin
          if (start_accept) begin
            state_q      <= HIGH;
            pulse_q      <= 1'b1;
            cnt_q        <= next_width - W_ONE;
            last_width_q <= next_width;
          end
        end
        HIGH: begin
          if (stop_rise) stop_pending_q <= 1'b1;
          if (cnt_q == '0) begin
            state_q <= LOW;
            pulse_q <= 1'b0;
            cnt_q   <= GAP_LOAD;
            if (count_q != '1) count_q <= count_q + COUNT_BITS'(1);
          end else begin
            cnt_q <= cnt_q - W_ONE;
          end
        end
        LOW: begin
          if (gap_done) begin
            if (reload) begin
              state_q      <= HIGH;
              pulse_q      <= 1'b1;
              cnt_q        <= next_width - W_ONE;
              last_width_q <= next_width;
            end else begin
              state_q        <= IDLE;
              stop_pending_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - W_ONE;
            if (stop_rise) stop_pending_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pulse_out   = pulse_q;
  assign busy        = (state_q != IDLE);
  assign pulse_count = count_q;
  assign last_width  = last_width_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Self-checking bench for pulse_train_generator: expected widths are queued as pulses
// are requested and a monitor measures each emitted pulse and gap against them.
module tb_pulse_train_generator;

  localparam int MIN_W = 4;
  localparam int GAP   = 8;

  logic        clk = 1'b0;
  logic        areset_n;
  logic        start, stop, bram_reset_done;
  logic        pulse_out, busy;
  logic [15:0] pulse_count;
  logic [8:0]  last_width;

  int          total = 0;
  int          bad   = 0;
  int          expQ[$];
  logic [15:0] mLfsr;
  int          sweepCnt;
  int          w1, w2, w3;

  pulse_train_generator dut (
    .clk            (clk),
    .areset_n       (areset_n),
    .start          (start),
    .stop           (stop),
    .bram_reset_done(bram_reset_done),
    .pulse_out      (pulse_out),
    .busy           (busy),
    .pulse_count    (pulse_count),
    .last_width     (last_width)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] lfsrStep(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic modelReset();
    mLfsr    = 16'hACE1;
    sweepCnt = 0;
    expQ.delete();
  endtask

  task automatic pushNextWidth(output int w);
`ifdef PULSE_GEN_SWEEP_EN
    w        = MIN_W + sweepCnt;
    sweepCnt = (sweepCnt + 1) % 256;
`else
    mLfsr = lfsrStep(mLfsr);
    w     = MIN_W + int'(mLfsr[7:0]);
`endif
    expQ.push_back(w);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic b);
    start           = s;
    stop            = p;
    bram_reset_done = b;
  endtask

  task automatic waitCount(input int target, input int budget);
    int n = 0;
    while (int'(pulse_count) < target && n < budget) begin
      tick(1);
      n++;
    end
    if (int'(pulse_count) < target) checkOutput("timeout_count", pulse_count, target);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    if (busy) checkOutput("timeout_idle", busy, 0);
  endtask

  task automatic waitFall(input int budget);
    int n = 0;
    while (pulse_out && n < budget) begin
      tick(1);
      n++;
    end
    if (pulse_out) checkOutput("timeout_fall", pulse_out, 0);
  endtask

  // Monitor: measures high and gap lengths at the falling edge of clk.
  logic prevPulse = 1'b0;
  logic afterFall = 1'b0;
  int   highLen   = 0;
  int   lowLen    = 0;

  always @(negedge clk) begin
    if (!areset_n) begin
      prevPulse = 1'b0;
      afterFall = 1'b0;
      highLen   = 0;
      lowLen    = 0;
    end else begin
      if (pulse_out && !prevPulse) begin
        if (afterFall) checkOutput("gap_len", lowLen, GAP);
        afterFall = 1'b0;
        highLen   = 1;
      end else if (pulse_out) begin
        highLen++;
      end else if (prevPulse) begin
        if (expQ.size() == 0) checkOutput("unexpected_pulse", highLen, 0);
        else checkOutput("pulse_width", highLen, expQ.pop_front());
        afterFall = 1'b1;
        lowLen    = 1;
      end else if (afterFall) begin
        lowLen++;
      end
      if (!busy) afterFall = 1'b0;
      prevPulse = pulse_out;
    end
  end

  initial begin
    areset_n = 1'b0;
    applyStimulus(0, 0, 0);
    modelReset();
    tick(3);
    #1;
    checkOutput("rst_pulse", pulse_out, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_count", pulse_count, 0);
    checkOutput("rst_lastw", last_width, 0);
    areset_n = 1'b1;
    tick(2);

    // Two-pulse train, then stop during the second gap
    applyStimulus(0, 0, 1);
    tick(2);
    applyStimulus(1, 0, 1);
    pushNextWidth(w1);
    pushNextWidth(w2);
    tick(1);
    checkOutput("start_latency", pulse_out, 1);
    checkOutput("busy_on", busy, 1);
    checkOutput("lastw_first", last_width, w1);
    waitCount(1, 600);
    waitCount(2, 600);
    checkOutput("lastw_second", last_width, w2);
    applyStimulus(1, 1, 1);
    waitIdle(50);
    tick(300);
    checkOutput("count_after_stop", pulse_count, 2);
    checkOutput("pulse_after_stop", pulse_out, 0);

    // Stop 10 cycles into a pulse: full width, one gap, then idle
    areset_n = 1'b0;
    applyStimulus(0, 0, 1);
    modelReset();
    tick(2);
    areset_n = 1'b1;
    tick(2);
    applyStimulus(1, 0, 1);
    pushNextWidth(w1);
    tick(10);
    applyStimulus(1, 1, 1);
    waitFall(600);
    tick(7);
    checkOutput("busy_in_gap", busy, 1);
    tick(1);
    checkOutput("busy_after_gap", busy, 0);
    tick(200);
    checkOutput("count_single", pulse_count, 1);

    // Start without bram_reset_done is dropped; start+stop together does nothing
    applyStimulus(0, 0, 0);
    tick(2);
    applyStimulus(1, 0, 0);
    tick(1);
    applyStimulus(1, 0, 1);
    tick(20);
    checkOutput("nobram_busy", busy, 0);
    checkOutput("nobram_pulse", pulse_out, 0);
    applyStimulus(0, 0, 1);
    tick(2);
    applyStimulus(1, 1, 1);
    tick(20);
    checkOutput("startstop_busy", busy, 0);
    checkOutput("startstop_count", pulse_count, 1);

    // Reset in the middle of the second pulse
    areset_n = 1'b0;
    applyStimulus(0, 0, 1);
    modelReset();
    tick(2);
    areset_n = 1'b1;
    tick(2);
    applyStimulus(1, 0, 1);
    pushNextWidth(w1);
    pushNextWidth(w2);
    waitCount(1, 600);
    tick(GAP + 2);
    checkOutput("mid_pulse_high", pulse_out, 1);
    areset_n = 1'b0;
    #1;
    checkOutput("arst_pulse", pulse_out, 0);
    checkOutput("arst_count", pulse_count, 0);
    checkOutput("arst_lastw", last_width, 0);
    modelReset();
    applyStimulus(0, 0, 1);
    tick(2);
    areset_n = 1'b1;
    tick(50);
    checkOutput("no_resume_busy", busy, 0);
    checkOutput("no_resume_pulse", pulse_out, 0);
    applyStimulus(1, 0, 1);
    pushNextWidth(w3);
    tick(1);
    checkOutput("restart_pulse", pulse_out, 1);
    checkOutput("restart_lastw", last_width, w3);
    applyStimulus(1, 1, 1);
    waitIdle(600);
    checkOutput("restart_count", pulse_count, 1);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
